reorder_seq_ctrl: RTL
=====================

Name: reorder_seq_ctrl

Overview:
- Block-level sequencer for the radix-3 digit-reversal reorder unit in the FFT/DFT path of the PUSCH receiver.
- Accepts a per-block size configuration (stage count 1..5, N = 3^stages = 3/9/27/81/243).
- Drives the reorder unit's Stages select and holds it stable for the whole block.
- Gates input samples into the reorder unit, counts samples in and out, and reports block completion, configuration errors and drain timeouts.

Parameters:
- CNT_W, 8, width of the sample counters; must hold 243.
- TIMEOUT, 1024, maximum cycles allowed in DRAIN before abort.
- TO_W, 11, width of the drain watchdog counter; must hold TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_valid  in  1  configuration request.
- cfg_stages  in  3  requested stage count; valid range 1..5.
- cfg_ready  out  1  high when a configuration can be accepted (IDLE).
- cfg_err  out  1  one-cycle pulse when a request is rejected.
- in_valid  in  1  upstream sample valid.
- in_ready  out  1  controller accepts samples (LOAD state).
- stages  out  3  Stages select to the reorder unit.
- rdr_di_en  out  1  sample enable to the reorder unit.
- rdr_do_en  in  1  output-valid strobe from the reorder unit.
- busy  out  1  high in LOAD, DRAIN and DONE.
- in_idx  out  CNT_W  index of the next input sample within the block.
- blk_done  out  1  one-cycle pulse when N outputs have been observed.
- timeout_err  out  1  one-cycle pulse when a DRAIN abort occurs.

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE; stages = 0, which disables the reorder unit's outputs.
  - in_idx = 0; out_cnt = 0; watchdog = 0.
  - cfg_err, blk_done and timeout_err are 0.
- Combinational outputs:
  - cfg_ready = (state == IDLE).
  - in_ready = (state == LOAD).
  - rdr_di_en = in_valid & in_ready.
  - busy = (state != IDLE).
- Size lookup, registered at accept: 1→3, 2→9, 3→27, 4→81, 5→243.
- IDLE:
  - Request cfg_valid with cfg_stages in 1..5 is accepted: stages <= cfg_stages, N is latched, in_idx and out_cnt are cleared, next state is LOAD.
  - Request cfg_valid with cfg_stages of 0, 6 or 7 is rejected: cfg_err pulses on the next cycle, the controller stays in IDLE, and stages is unchanged.
  - rdr_do_en is ignored in IDLE.
- LOAD:
  - Each cycle with rdr_di_en: in_idx increments.
  - Each cycle with rdr_do_en while out_cnt < N: out_cnt increments. Output counting is required in LOAD because stages = 1 is a zero-latency pass-through.
  - When the last input is accepted (in_idx == N-1 and rdr_di_en):
    - If out_cnt reaches N in the same cycle, next state is DONE.
    - Otherwise next state is DRAIN, with the watchdog cleared.
- DRAIN:
  - in_ready = 0.
  - out_cnt counts rdr_do_en strobes; the watchdog increments every cycle.
  - When out_cnt reaches N (including the current cycle's strobe), next state is DONE.
  - When the watchdog reaches TIMEOUT-1 without completion, timeout_err pulses and next state is IDLE. If completion and timeout occur in the same cycle, completion wins.
- DONE:
  - Lasts one cycle; blk_done = 1; next state is IDLE.
- Configuration during LOAD/DRAIN/DONE:
  - cfg_ready = 0, so cfg_valid is ignored: no error, no change to stages.
- stages holds its value from accept until the next accepted configuration. It is never changed while busy.
- Extra rdr_do_en strobes beyond N saturate out_cnt and are ignored.
- Reset mid-block returns all state to reset values immediately; the partial block is discarded.
- A configuration is accepted no earlier than the cycle after DONE; the minimum block-to-block gap is 1 cycle of IDLE.

Test Plan:
- stages=1 block: cfg_stages=1, in_valid held high, rdr_do_en mirrors rdr_di_en → 3 accepted samples, blk_done pulses 1 cycle after the third sample, DRAIN never entered.
- stages=3 block: 27 samples with in_valid low on every other cycle, rdr_do_en model delaying 27 cycles → in_idx steps 0..26, stages=3 held throughout, blk_done after the 27th output, busy falls the next cycle.
- Invalid configurations: cfg_stages=0 then 6 → cfg_err pulses twice, cfg_ready stays 1, stages stays 0.
- Configuration while busy: cfg_stages=2 issued during LOAD of a stages=5 block → ignored, stages stays 5, block completes after 243 in and 243 out.
- Timeout: stages=2, 9 inputs, only 5 rdr_do_en strobes → timeout_err pulses exactly TIMEOUT cycles after DRAIN entry, no blk_done, state returns to IDLE.
- Reset mid-DRAIN: rst asserted with out_cnt=40 of 81 → outputs take reset values asynchronously, and a new stages=4 configuration after reset completes normally.

Source files
------------

// File: rtl/reorder_seq_ctrl.sv
// Block sequencer for the radix-3 digit-reversal reorder unit: latches the block size,
// gates samples in, counts samples out, and flags completion, bad configs and drain timeouts.
module reorder_seq_ctrl #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned TO_W    = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  input  logic [2:0]       cfg_stages,
  output logic             cfg_ready,
  output logic             cfg_err,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [2:0]       stages,
  output logic             rdr_di_en,
  input  logic             rdr_do_en,
  output logic             busy,
  output logic [CNT_W-1:0] in_idx,
  output logic             blk_done,
  output logic             timeout_err
);

  typedef enum logic [1:0] {StIdle, StLoad, StDrain, StDone} state_e;

  state_e           state_q, state_d;
  logic [2:0]       stages_q, stages_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [CNT_W-1:0] in_idx_q, in_idx_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [TO_W-1:0]  wd_q, wd_d;
  logic             cfg_err_q, cfg_err_d;
  logic             timeout_err_q, timeout_err_d;

  logic [CNT_W-1:0] cfg_n;
  logic             cfg_ok;
  logic [CNT_W-1:0] out_cnt_inc;

  always_comb begin
    cfg_n = '0;
    unique case (cfg_stages)
      3'd1:    cfg_n = CNT_W'(3);
      3'd2:    cfg_n = CNT_W'(9);
      3'd3:    cfg_n = CNT_W'(27);
      3'd4:    cfg_n = CNT_W'(81);
      3'd5:    cfg_n = CNT_W'(243);
      default: cfg_n = '0;
    endcase
  end

  assign cfg_ok = (cfg_stages >= 3'd1) && (cfg_stages <= 3'd5);

  assign cfg_ready   = (state_q == StIdle);
  assign in_ready    = (state_q == StLoad);
  assign rdr_di_en   = in_valid & in_ready;
  assign busy        = (state_q != StIdle);
  assign blk_done    = (state_q == StDone);
  assign stages      = stages_q;
  assign in_idx      = in_idx_q;
  assign cfg_err     = cfg_err_q;
  assign timeout_err = timeout_err_q;

  // Output count saturates at N so stray strobes past the block end are dropped.
  assign out_cnt_inc = (rdr_do_en && (out_cnt_q < n_q)) ? out_cnt_q + CNT_W'(1) : out_cnt_q;

  always_comb begin
    state_d       = state_q;
    stages_d      = stages_q;
    n_d           = n_q;
    in_idx_d      = in_idx_q;
    out_cnt_d     = out_cnt_q;
    wd_d          = wd_q;
    cfg_err_d     = 1'b0;
    timeout_err_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cfg_valid) begin
          if (cfg_ok) begin
            stages_d  = cfg_stages;
            n_d       = cfg_n;
            in_idx_d  = '0;
            out_cnt_d = '0;
            state_d   = StLoad;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      StLoad: begin
        // Outputs are counted here too: a single stage passes samples straight through.
        out_cnt_d = out_cnt_inc;
        if (rdr_di_en) begin
          in_idx_d = in_idx_q + CNT_W'(1);
          if (in_idx_q == n_q - CNT_W'(1)) begin
            if (out_cnt_inc == n_q) begin
              state_d = StDone;
            end else begin
              state_d = StDrain;
              wd_d    = '0;
            end
          end
        end
      end
      StDrain: begin
        out_cnt_d = out_cnt_inc;
        wd_d      = wd_q + TO_W'(1);
        if (out_cnt_inc == n_q) begin
          state_d = StDone;
        end else if (wd_q == TO_W'(TIMEOUT - 1)) begin
          state_d       = StIdle;
          timeout_err_d = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      stages_q      <= 3'd0;
      n_q           <= '0;
      in_idx_q      <= '0;
      out_cnt_q     <= '0;
      wd_q          <= '0;
      cfg_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      stages_q      <= stages_d;
      n_q           <= n_d;
      in_idx_q      <= in_idx_d;
      out_cnt_q     <= out_cnt_d;
      wd_q          <= wd_d;
      cfg_err_q     <= cfg_err_d;
      timeout_err_q <= timeout_err_d;
    end
  end

endmodule
